count_down_ctrl: RTL
====================

Name: count_down_ctrl

Overview:
Countdown controller for the count game. It loads a seconds value and counts it down at 1 Hz, derived from the 1 kHz system clock, presenting the remaining time as two BCD digits. At zero it drives the active-high run/enable input of the downstream beep stage. It then waits for that stage's "over" flag before returning to idle. The block sits directly upstream of the beeper and owns the beeper's start/clear line.

Parameters:
CLK_HZ, 1000, system clock cycles per second; tick counter wraps at CLK_HZ-1
DEFAULT_SEC, 30, value shown on the display after reset (0..99)
MAX_SEC, 99, clamp ceiling for the loaded value
ALARM_MAX, 8000, ALARM-state timeout in clk cycles; forced exit if beep_over never arrives

Ports:
clk  in  1  system clock, 1 kHz nominal
st  in  1  asynchronous active-low reset
start  in  1  single-cycle start/resume pulse, from the debouncer, synchronous to clk
pause  in  1  single-cycle pause/resume toggle pulse, synchronous
load_val  in  7  preset seconds, unsigned binary
beep_over  in  1  "over" flag from the beep stage, level
sec_tens  out  4  remaining seconds, tens digit (BCD)
sec_ones  out  4  remaining seconds, ones digit (BCD)
running  out  1  high in RUN
beep_st  out  1  beep stage enable; low holds the beeper cleared
done  out  1  one-cycle pulse when a countdown cycle completes

Behaviour:
- Reset and clocking: one clock, clk. Reset st is asynchronous and active-low.
  - Reset values: state=IDLE, tick=0, tens/ones=BCD(DEFAULT_SEC), running=0, beep_st=0, done=0, alarm timer=0.
  - All outputs are registered.
- States: IDLE, RUN, PAUSE, ALARM.
- IDLE:
  - The display holds its last value.
  - On start: v = min(load_val, MAX_SEC); tens/ones=BCD(v); tick=0.
  - If v==0, go directly to ALARM; otherwise go to RUN.
  - pause and beep_over are ignored in IDLE.
- RUN:
  - tick increments every cycle.
  - When tick==CLK_HZ-1: tick wraps to 0 and the BCD value decrements. If ones==0, then ones=9 and tens=tens-1; otherwise ones=ones-1.
  - If the decrement yields 00, enter ALARM on the same edge.
  - pause moves to PAUSE with tick frozen.
  - If pause coincides with the wrap, the decrement still happens and the next state is PAUSE. If the decrement reaches 00 on that edge, ALARM wins and pause is dropped.
  - start is ignored in RUN.
- PAUSE:
  - tick and digits hold.
  - start or pause returns to RUN, resuming from the frozen tick value with no lost or extra count.
- ALARM:
  - beep_st=1 from the first ALARM cycle; alarm timer counts cycles.
  - Exit to IDLE when beep_over==1 or when the timer reaches ALARM_MAX-1.
  - On exit: beep_st=0, done=1 for exactly one cycle, timer=0. Digits remain 00.
  - start and pause are ignored in ALARM.
- beep_st is low in every non-ALARM state. After any ALARM exit it stays low for at least one cycle, so the beeper's "over" flag is cleared before it is re-armed. A start on the first IDLE cycle is legal; the RUN duration guarantees the low gap.
- Latency: start to running=1 is 1 cycle. Final wrap to beep_st=1 is 1 cycle. beep_over=1 to done=1 is 1 cycle.
- running=1 only in RUN.
- Digit invariant: digits are always valid BCD, with no underflow below 00.
- Tick counter width: clog2(CLK_HZ).
- An st assertion in any state, including mid-ALARM, immediately forces the reset values. beep_st drops asynchronously.

Test Plan:
- CLK_HZ=10: reset, then start with load_val=3 -> digits 03, 02, 01, 00 at 10-cycle spacing; beep_st=1 on the cycle after the 00 wrap.
- load_val=10: one tick -> digits go 10 -> 09 (tens/ones borrow).
- load_val=120 -> clamps to 99. load_val=0 -> ALARM on the cycle after start, with digits 00.
- Pause pulse at tick=4, hold 50 cycles, then start -> the next decrement occurs 6 cycles after resume; digits unchanged during PAUSE.
- In ALARM, raise beep_over -> next cycle beep_st=0, done=1 for one cycle, state IDLE. With beep_over held low and ALARM_MAX=20 -> exit after 20 cycles.
- Assert st low mid-RUN and mid-ALARM -> immediate beep_st=0, running=0, digits=30.

Source files
------------

// File: rtl/count_down_ctrl.sv
// Countdown controller: loads seconds, counts down at 1 Hz from CLK_HZ, shows two BCD digits.
// On reaching 00 it enables the beep stage until beep_over or an alarm timeout, then returns to idle.
module count_down_ctrl #(
  parameter int CLK_HZ      = 1000,
  parameter int DEFAULT_SEC = 30,
  parameter int MAX_SEC     = 99,
  parameter int ALARM_MAX   = 8000
) (
  input  logic       clk,
  input  logic       st,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] load_val,
  input  logic       beep_over,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       beep_st,
  output logic       done
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = (ALARM_MAX > 1) ? $clog2(ALARM_MAX) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_MAX - 1);
  localparam logic [6:0]    MAX_V      = 7'(MAX_SEC);
  localparam logic [3:0]    RST_TENS   = 4'(DEFAULT_SEC / 10);
  localparam logic [3:0]    RST_ONES   = 4'(DEFAULT_SEC % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [AW-1:0] timer_q, timer_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic          running_q, running_d;
  logic          beep_st_q, beep_st_d;
  logic          done_q, done_d;

  logic [6:0] load_v;
  logic [3:0] load_tens, load_ones, dec_tens, dec_ones;
  logic       wrap, dec_zero;

  always_comb begin
    load_v    = (load_val > MAX_V) ? MAX_V : load_val;
    load_tens = 4'(load_v / 7'd10);
    load_ones = 4'(load_v % 7'd10);
    wrap      = (tick_q == TICK_LAST);
    // BCD borrow: ones rolls 0 -> 9 and takes one from tens
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end else begin
      dec_ones = ones_q - 4'd1;
      dec_tens = tens_q;
    end
    dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    timer_d = timer_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tens_d  = load_tens;
          ones_d  = load_ones;
          tick_d  = '0;
          state_d = (load_v == 7'd0) ? ALARM : RUN;
        end
      end
      RUN: begin
        if (wrap) begin
          tick_d = '0;
          tens_d = dec_tens;
          ones_d = dec_ones;
          // reaching 00 takes priority over a coincident pause
          if (dec_zero)   state_d = ALARM;
          else if (pause) state_d = PAUSE;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PAUSE: begin
        if (start || pause) state_d = RUN;
      end
      ALARM: begin
        if (beep_over || (timer_q == ALARM_LAST)) begin
          state_d = IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    beep_st_d = (state_d == ALARM);
  end

  always_ff @(posedge clk or negedge st) begin
    if (!st) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      timer_q   <= '0;
      tens_q    <= RST_TENS;
      ones_q    <= RST_ONES;
      running_q <= 1'b0;
      beep_st_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      timer_q   <= timer_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      beep_st_q <= beep_st_d;
      done_q    <= done_d;
    end
  end

  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign running  = running_q;
  assign beep_st  = beep_st_q;
  assign done     = done_q;

endmodule
